// File: rtl/rega_input_pkg.sv
// Shared types and constants for the rega input conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a; no flow control in this slice.
package rega_input_pkg;

  // Debounce FSM states. The two CONFIRM states count ticks toward a level change.
  typedef enum logic [1:0] {
    IDLE_LOW     = 2'd0,
    CONFIRM_HIGH = 2'd1,
    IDLE_HIGH    = 2'd2,
    CONFIRM_LOW  = 2'd3
  } deb_state_t;

  // Channel bit positions inside raw_in / level_out.
  localparam int CH_ASP = 0;
  localparam int CH_GOT = 1;
  localparam int CH_ADB = 2;

  localparam int DEFAULT_DEBOUNCE_TICKS = 4;
  localparam int DEFAULT_STUCK_TICKS    = 1024;

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: 2-flop synchronizer, tick-paced debounce FSM, edge pulses.
// Latency: 2 clocks sync + 1 clock FSM entry + DEBOUNCE_TICKS ticks raw -> level.
// Backpressure: none; free-running, every clock.
//
// Ports: clock, reset (async active-low), raw (unsynchronized), tick (count enable),
//        level (debounced), rise/fall (one-clock edge pulses), stuck (high too long).
// Build option: RAGA_STUCK_DETECT_EN enables the stuck-high counter; otherwise stuck = 0.
module debounce_channel
  import rega_input_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter int STUCK_TICKS    = DEFAULT_STUCK_TICKS
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall,
  output logic stuck
);

  if (DEBOUNCE_TICKS < 1 || STUCK_TICKS < 1) begin : g_bad_param
    $error("debounce_channel: DEBOUNCE_TICKS and STUCK_TICKS must be >= 1");
  end

  localparam int CW = $clog2(DEBOUNCE_TICKS) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic       sync_d;
  logic       sync_q;
  deb_state_t state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_d <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      sync_d <= raw;
      sync_q <= sync_d;
    end
  end

  // A bounce (sync_q returning to the accepted level) is tested before the
  // tick, so it wins when both happen in the same clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (sync_q) begin
            state <= CONFIRM_HIGH;
            cnt   <= '0;
          end
        end
        CONFIRM_HIGH: begin
          if (!sync_q) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == CNT_LAST) begin
              state <= IDLE_HIGH;
              cnt   <= '0;
              level <= 1'b1;
              rise  <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        IDLE_HIGH: begin
          if (!sync_q) begin
            state <= CONFIRM_LOW;
            cnt   <= '0;
          end
        end
        CONFIRM_LOW: begin
          if (sync_q) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == CNT_LAST) begin
              state <= IDLE_LOW;
              cnt   <= '0;
              level <= 1'b0;
              fall  <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= IDLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef RAGA_STUCK_DETECT_EN
  localparam int SW = $clog2(STUCK_TICKS) + 1;
  localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_TICKS - 1);

  logic [SW-1:0] stuck_cnt;
  logic          stuck_q;

  // Saturates once set; any exit from IDLE_HIGH (even a bounce into
  // CONFIRM_LOW) restarts the measurement.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stuck_cnt <= '0;
      stuck_q   <= 1'b0;
    end else if (state == IDLE_HIGH) begin
      if (tick && !stuck_q) begin
        if (stuck_cnt == STUCK_LAST) stuck_q <= 1'b1;
        else                         stuck_cnt <= stuck_cnt + SW'(1);
      end
    end else begin
      stuck_cnt <= '0;
      stuck_q   <= 1'b0;
    end
  end

  assign stuck = stuck_q;
`else
  assign stuck = 1'b0;
`endif

endmodule

// File: rtl/rega_input_conditioner.sv
// Irrigation front end: debounced levels, edge pulses and asp/got conflict flag.
// Latency: 2 sync + 1 entry clocks + DEBOUNCE_TICKS ticks to level; conflict +1 clock.
// Backpressure: none; outputs update every clock.
//
// Ports: clock, reset (async active-low), raw_in[CHANNELS], tick,
//        level_out/rise_pulse/fall_pulse/stuck[CHANNELS], conflict.
// Build option: RAGA_STUCK_DETECT_EN enables per-channel stuck-high flags.
module rega_input_conditioner
  import rega_input_pkg::*;
#(
  parameter int CHANNELS       = 3,
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter int STUCK_TICKS    = DEFAULT_STUCK_TICKS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  input  logic                tick,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                conflict,
  output logic [CHANNELS-1:0] stuck
);

  if (CHANNELS < 2) begin : g_bad_channels
    $error("rega_input_conditioner: CHANNELS must be >= 2 (asp and got)");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .STUCK_TICKS   (STUCK_TICKS)
    ) u_ch (
      .clock(clock),
      .reset(reset),
      .raw  (raw_in[i]),
      .tick (tick),
      .level(level_out[i]),
      .rise (rise_pulse[i]),
      .fall (fall_pulse[i]),
      .stuck(stuck[i])
    );
  end

  // Sprinkler and drip must not run together; flagged one clock after both levels are high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) conflict <= 1'b0;
    else        conflict <= level_out[CH_ASP] & level_out[CH_GOT];
  end

endmodule

// File: tb/tb_rega_input_conditioner.sv
// Randomized + directed bench with a per-clock scoreboard against a tick-counting model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rega_input_conditioner;
  import rega_input_pkg::*;

  localparam int CH = 3;
  localparam int DT = 4;
  localparam int ST = 8;

  typedef struct packed {
    logic [CH-1:0] level;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          conf;
    logic [CH-1:0] stuck;
  } obs_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] raw_in = '0;
  logic          tick = 1'b0;
  logic [CH-1:0] level_out, rise_pulse, fall_pulse, stuck;
  logic          conflict;

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;
  int cyc = 0;

  obs_t exp_q[$];

  rega_input_conditioner #(
    .CHANNELS(CH), .DEBOUNCE_TICKS(DT), .STUCK_TICKS(ST)
  ) dut (
    .clock(clock), .reset(reset), .raw_in(raw_in), .tick(tick),
    .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .conflict(conflict), .stuck(stuck)
  );

  always #5 clock = ~clock;

  // Reference model: raw seen two clocks late; a differing value is accepted
  // after it has survived DT ticks following its first appearance; any return
  // to the accepted level abandons the attempt.
  logic [CH-1:0] m_s1 = '0, m_s2 = '0, m_level = '0, m_pend = '0;
  logic [CH-1:0] m_rise = '0, m_fall = '0, m_stuck = '0;
  logic          m_conf = 1'b0;
  int            m_ticks[CH];
  int            m_hi_ticks[CH];

  always @(posedge clock) begin
    obs_t e;
    logic [CH-1:0] old_level, old_pend;
    cyc++;
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_pend = '0;
      m_rise = '0; m_fall = '0; m_stuck = '0; m_conf = 1'b0;
      for (int i = 0; i < CH; i++) begin m_ticks[i] = 0; m_hi_ticks[i] = 0; end
    end else begin
      old_level = m_level;
      old_pend  = m_pend;
      m_conf = old_level[CH_ASP] & old_level[CH_GOT];
      for (int i = 0; i < CH; i++) begin
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (old_pend[i]) begin
          if (m_s2[i] == old_level[i]) m_pend[i] = 1'b0;
          else if (tick) begin
            m_ticks[i]++;
            if (m_ticks[i] == DT) begin
              m_level[i] = ~old_level[i];
              m_pend[i]  = 1'b0;
              if (m_level[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
            end
          end
        end else if (m_s2[i] != old_level[i]) begin
          m_pend[i]  = 1'b1;
          m_ticks[i] = 0;
        end
        if (old_level[i] && !old_pend[i]) begin
          if (tick) begin
            if (m_hi_ticks[i] + 1 >= ST) m_stuck[i] = 1'b1;
            else m_hi_ticks[i]++;
          end
        end else begin
          m_hi_ticks[i] = 0;
          m_stuck[i] = 1'b0;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw_in;
    end
    e.level = m_level; e.rise = m_rise; e.fall = m_fall; e.conf = m_conf;
`ifdef RAGA_STUCK_DETECT_EN
    e.stuck = m_stuck;
`else
    e.stuck = '0;
`endif
    exp_q.push_back(e);
  end

  // Monitor: every clock the DUT presents a fresh output word.
  initial begin
    obs_t e, g;
    while (!done) begin
      @(posedge clock);
      #1;
      g.level = level_out; g.rise = rise_pulse; g.fall = fall_pulse;
      g.conf = conflict; g.stuck = stuck;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_empty cyc=%0d got=%h", cyc, g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL outputs cyc=%0d got lvl=%b r=%b f=%b c=%b s=%b want lvl=%b r=%b f=%b c=%b s=%b",
                   cyc, g.level, g.rise, g.fall, g.conf, g.stuck,
                   e.level, e.rise, e.fall, e.conf, e.stuck);
        end
      end
    end
  end

  task automatic drive(input logic [CH-1:0] r, input logic t, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      raw_in = r;
      tick = t;
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    // Reset held with all inputs high, then released.
    drive(3'b111, 1'b1, 4);
    @(negedge clock); reset = 1'b1;
    drive(3'b111, 1'b1, 12);
    drive(3'b000, 1'b1, 12);
    // Bounce on asp: three clocks high only.
    drive(3'b001, 1'b1, 3);
    drive(3'b000, 1'b1, 10);
    // Tick gating on adb: tick every 4th clock.
    for (int k = 0; k < 32; k++) drive(3'b100, (k % 4) == 3, 1);
    drive(3'b000, 1'b1, 12);
    // Conflict: asp + got high, then got drops.
    drive(3'b011, 1'b1, 12);
    drive(3'b001, 1'b1, 12);
    drive(3'b011, 1'b1, 12);
    // Asynchronous reset while levels are high clears outputs immediately.
    @(negedge clock); reset = 1'b0;
    #1;
    checks++;
    if (level_out !== 3'b000 || conflict !== 1'b0 || rise_pulse !== 3'b000) begin
      failures++;
      $display("FAIL async_reset got lvl=%b c=%b r=%b want 000/0/000", level_out, conflict, rise_pulse);
    end
    drive(3'b000, 1'b1, 2);
    @(negedge clock); reset = 1'b1;
    drive(3'b000, 1'b1, 4);
    // Reset mid-confirmation on got.
    drive(3'b010, 1'b1, 5);
    @(negedge clock); reset = 1'b0;
    drive(3'b010, 1'b1, 2);
    @(negedge clock); reset = 1'b1;
    drive(3'b010, 1'b1, 12);
    drive(3'b000, 1'b1, 12);
    // Long adb high (stuck behaviour when enabled), then release.
    drive(3'b100, 1'b1, 30);
    drive(3'b000, 1'b1, 15);
    // Random traffic with occasional bounces, sparse ticks and resets.
    begin
      logic [CH-1:0] r;
      r = '0;
      for (int k = 0; k < 4000; k++) begin
        for (int i = 0; i < CH; i++)
          if ($urandom_range(0, 11) == 0) r[i] = ~r[i];
        @(negedge clock);
        raw_in = r;
        tick = ($urandom_range(0, 2) != 0);
        reset = ($urandom_range(0, 499) != 0);
      end
      @(negedge clock); reset = 1'b1;
    end
    drive(3'b000, 1'b1, 3);
    done = 1'b1;
    @(posedge clock);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
